plot_arbiter: RTL and testbench

- Shares the single VGA adapter plot port (x, y, colour, plot) between NUM_REQ drawing engines, such as stair objects, the player sprite and the background eraser.
- Grants the port to one requester at a time for a whole drawing burst, using round-robin priority.
- Forces rotation after MAX_BURST pixels so that no engine can starve the others.
- Sits between the drawing datapaths and the vga_adapter instance in the top level.

---
 rtl/plot_arbiter.sv | 141 ++++++++++++++
 tb/tb_plot_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_arbiter.sv
// Round-robin arbiter sharing the VGA plot port between drawing engines.
// Optional PLOT_CLIP_EN: suppress off-screen pixels and count them on clip_cnt.
module plot_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 1024,
  parameter int CNT_W     = 11
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [NUM_REQ-1:0]   last,
  input  logic [8*NUM_REQ-1:0] in_x,
  input  logic [7*NUM_REQ-1:0] in_y,
  input  logic [3*NUM_REQ-1:0] in_colour,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [7:0]           out_x,
  output logic [6:0]           out_y,
  output logic [2:0]           out_colour,
  output logic                 plot,
  output logic                 busy
`ifdef PLOT_CLIP_EN
  ,
  output logic [15:0]          clip_cnt
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    cur;
  logic [PW-1:0]    win;
  logic [PW-1:0]    nxt;
  logic             found;
  logic [CNT_W-1:0] cnt;
  int               idx;

  logic       c_req;
  logic       c_valid;
  logic       c_last;
  logic       accept;
  logic       rel;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_c;

  assign c_req   = req[cur];
  assign c_valid = valid[cur];
  assign c_last  = last[cur];
  assign sel_x   = in_x[8*int'(cur) +: 8];
  assign sel_y   = in_y[7*int'(cur) +: 7];
  assign sel_c   = in_colour[3*int'(cur) +: 3];
  assign nxt     = (cur == PW'(NUM_REQ-1)) ? '0 : cur + 1'b1;

  // A dropped req discards the pixel unless it also carried last.
  assign accept = (state == GRANT) && c_valid && (c_last || c_req);
  assign rel    = (state == GRANT) &&
                  ((c_valid && c_last) || !c_req ||
                   (c_valid && cnt == CNT_W'(MAX_BURST-1)));

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

`ifdef PLOT_CLIP_EN
  logic clip;
  assign clip = (sel_x >= 8'd160) || (sel_y >= 7'd120);
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt        <= '0;
      busy       <= 1'b0;
      ptr        <= '0;
      cur        <= '0;
      cnt        <= '0;
      plot       <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_colour <= '0;
`ifdef PLOT_CLIP_EN
      clip_cnt   <= '0;
`endif
    end else begin
      plot <= 1'b0;
      if (accept) begin
        out_x      <= sel_x;
        out_y      <= sel_y;
        out_colour <= sel_c;
`ifdef PLOT_CLIP_EN
        plot <= !clip;
        if (clip && clip_cnt != 16'hFFFF)
          clip_cnt <= clip_cnt + 16'd1;
`else
        plot <= 1'b1;
`endif
      end
      unique case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            cur   <= win;
            gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (accept && cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
          if (rel) begin
            state <= GAP;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= nxt;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter (MAX_BURST=8 to exercise preemption).
// Clip checks run only when PLOT_CLIP_EN is defined.
module tb_plot_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  valid;
  logic [3:0]  last;
  logic [31:0] in_x;
  logic [27:0] in_y;
  logic [11:0] in_colour;
  logic [3:0]  gnt;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [2:0]  out_colour;
  logic        plot;
  logic        busy;
`ifdef PLOT_CLIP_EN
  logic [15:0] clip_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  plot_arbiter #(
    .NUM_REQ  (4),
    .MAX_BURST(8),
    .CNT_W    (11)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .valid     (valid),
    .last      (last),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_colour (in_colour),
    .gnt       (gnt),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_colour(out_colour),
    .plot      (plot),
    .busy      (busy)
`ifdef PLOT_CLIP_EN
    ,
    .clip_cnt  (clip_cnt)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_px(input int i, input logic [7:0] x,
                        input logic [6:0] y, input logic [2:0] c);
    in_x[8*i +: 8]      = x;
    in_y[7*i +: 7]      = y;
    in_colour[3*i +: 3] = c;
  endtask

  int p1;
  int p3;
  logic a1;
  logic a3;
  logic [31:0] got[$];
  logic [31:0] expq[$];

  task automatic drive_stream();
    req[1]   = (p1 < 20);
    valid[1] = (p1 < 20);
    last[1]  = (p1 == 19);
    set_px(1, 8'(p1), 7'd0, 3'd0);
    req[3]   = (p3 < 3);
    valid[3] = (p3 < 3);
    last[3]  = (p3 == 2);
    set_px(3, 8'(100 + p3), 7'd0, 3'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    valid     = '0;
    last      = '0;
    in_x      = '0;
    in_y      = '0;
    in_colour = '0;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_x", 32'(out_x), 0);
    chk("rst_y", 32'(out_y), 0);
    chk("rst_col", 32'(out_colour), 0);
    reset_n = 1'b1;
    step();
    chk("idle_gnt", 32'(gnt), 0);

    // single requester, five-pixel burst
    req[0] = 1'b1;
    set_px(0, 8'd10, 7'd20, 3'b101);
    step();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_busy", 32'(busy), 1);
    for (int k = 0; k < 5; k++) begin
      valid[0] = 1'b1;
      last[0]  = (k == 4);
      set_px(0, 8'(10 + k), 7'd20, 3'b101);
      step();
      chk("t1_plot", 32'(plot), 1);
      chk("t1_x", 32'(out_x), 32'(10 + k));
    end
    chk("t1_y", 32'(out_y), 20);
    chk("t1_col", 32'(out_colour), 5);
    chk("t1_rel", 32'(gnt), 0);
    req = '0;
    valid = '0;
    last = '0;
    step();
    chk("t1_gap_plot", 32'(plot), 0);
    chk("t1_hold_x", 32'(out_x), 14);
    step();
    chk("t1_idle_gnt", 32'(gnt), 0);
    chk("t1_idle_busy", 32'(busy), 0);

    // round robin between 0 and 2
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req = 4'b0101;
    set_px(0, 8'd30, 7'd1, 3'd1);
    set_px(2, 8'd40, 7'd2, 3'd2);
    step();
    chk("t2_gnt0", 32'(gnt), 32'h1);
    valid[0] = 1'b1;
    last[0]  = 1'b1;
    step();
    chk("t2_x0", 32'(out_x), 30);
    chk("t2_rel0", 32'(gnt), 0);
    req[0] = 1'b0;
    valid = '0;
    last = '0;
    step();
    chk("t2_gap", 32'(gnt), 0);
    step();
    chk("t2_gnt2", 32'(gnt), 32'h4);
    valid[2] = 1'b1;
    last[2]  = 1'b1;
    step();
    chk("t2_x2", 32'(out_x), 40);
    chk("t2_plot2", 32'(plot), 1);
    req = 4'b0101;
    valid = '0;
    last = '0;
    step();
    step();
    chk("t2_wrap", 32'(gnt), 32'h1);

    // req drop with valid high: pixel discarded
    req = 4'b0100;
    valid = 4'b0001;
    set_px(0, 8'd77, 7'd3, 3'd3);
    step();
    chk("t4_drop_plot", 32'(plot), 0);
    chk("t4_drop_x", 32'(out_x), 40);
    chk("t4_drop_gnt", 32'(gnt), 0);
    valid = '0;
    step();
    step();
    chk("t2_ptr1", 32'(gnt), 32'h4);
    req = '0;
    step();
    chk("t2_rel2", 32'(gnt), 0);
    step();
    step();

    // forced preemption with MAX_BURST=8
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    p1 = 0;
    p3 = 0;
    drive_stream();
    for (int cyc = 0; cyc < 300 && (p1 < 20 || p3 < 3); cyc++) begin
      a1 = gnt[1] & valid[1];
      a3 = gnt[3] & valid[3];
      step();
      if (a1) p1++;
      if (a3) p3++;
      if (plot) got.push_back(32'(out_x));
      drive_stream();
    end
    for (int k = 0; k < 8; k++) expq.push_back(32'(k));
    for (int k = 0; k < 3; k++) expq.push_back(32'(100 + k));
    for (int k = 8; k < 20; k++) expq.push_back(32'(k));
    chk("t3_count", 32'(got.size()), 32'(expq.size()));
    for (int k = 0; k < expq.size(); k++)
      chk($sformatf("t3_px%0d", k),
          (k < got.size()) ? got[k] : 32'hDEAD, expq[k]);

    // reset mid-burst, stale pointer is 2
    req = 4'b0001;
    valid = 4'b0001;
    last = '0;
    set_px(0, 8'd50, 7'd4, 3'd4);
    step();
    step();
    chk("t5_gnt", 32'(gnt), 32'h1);
    step();
    chk("t5_plot", 32'(plot), 1);
    chk("t5_x", 32'(out_x), 50);
    reset_n = 1'b0;
    step();
    chk("t5_rst_gnt", 32'(gnt), 0);
    chk("t5_rst_plot", 32'(plot), 0);
    chk("t5_rst_x", 32'(out_x), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    valid = '0;
    req = 4'b0101;
    step();
    chk("t5_ptr0", 32'(gnt), 32'h1);
    req = '0;
    step();
    step();
    step();

`ifdef PLOT_CLIP_EN
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req[0] = 1'b1;
    step();
    valid[0] = 1'b1;
    set_px(0, 8'd159, 7'd119, 3'd1);
    step();
    chk("clip_p1_plot", 32'(plot), 1);
    chk("clip_p1_x", 32'(out_x), 159);
    chk("clip_p1_cnt", 32'(clip_cnt), 0);
    last[0] = 1'b1;
    set_px(0, 8'd160, 7'd5, 3'd2);
    step();
    chk("clip_p2_plot", 32'(plot), 0);
    chk("clip_p2_x", 32'(out_x), 160);
    chk("clip_p2_cnt", 32'(clip_cnt), 1);
    chk("clip_p2_rel", 32'(gnt), 0);
    req = '0;
    valid = '0;
    last = '0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
